// File: rtl/io_bus_router_if.sv
// io_bus_router_if: request/response and device-side signal bundle for io_bus_router.
// slave  = the router's view (takes requests, drives device selects).
// master = the environment's view (core IO port plus peripherals).
// Optional macro IO_BUS_ROUTER_STATS_EN adds the err_count / err_addr outputs.
interface io_bus_router_if #(
    parameter int SLOT_BITS = 3,
    parameter int REG_BITS  = 4,
    parameter int NUM_SLOTS = 8,
    parameter int DATA_W    = 32
);
    localparam int ADDR_W = SLOT_BITS + REG_BITS;

    // core request / response
    logic                        req_valid;
    logic                        req_write;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic                        req_ready;
    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_error;

    // device side
    logic [NUM_SLOTS-1:0]        dev_sel;
    logic                        dev_write;
    logic [REG_BITS-1:0]         dev_reg_addr;
    logic [DATA_W-1:0]           dev_wdata;
    logic [NUM_SLOTS-1:0]        dev_ack;
    logic [NUM_SLOTS*DATA_W-1:0] dev_rdata;

`ifdef IO_BUS_ROUTER_STATS_EN
    logic [7:0]                  err_count;
    logic [ADDR_W-1:0]           err_addr;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, dev_ack, dev_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               dev_sel, dev_write, dev_reg_addr, dev_wdata,
               err_count, err_addr
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, dev_ack, dev_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               dev_sel, dev_write, dev_reg_addr, dev_wdata,
               err_count, err_addr
    );
`else
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, dev_ack, dev_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               dev_sel, dev_write, dev_reg_addr, dev_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, dev_ack, dev_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               dev_sel, dev_write, dev_reg_addr, dev_wdata
    );
`endif

endinterface

// File: rtl/io_bus_router.sv
// io_bus_router: single-outstanding IO request router.
// Splits the request address into {slot, reg}, drives a one-hot device select,
// waits for that slot's ack (bounded by TIMEOUT) and returns a one-cycle response.
// Slots >= NUM_SLOTS are reserved and answered immediately with an error.
// Optional macro IO_BUS_ROUTER_STATS_EN adds a saturating error counter and the
// address of the most recent error.
module io_bus_router #(
    parameter int SLOT_BITS = 3,
    parameter int REG_BITS  = 4,
    parameter int NUM_SLOTS = 8,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic            clk,
    input  logic            rst,
    io_bus_router_if.slave  bus
);
    localparam int ADDR_W = SLOT_BITS + REG_BITS;
    // One extra bit so NUM_SLOTS == 2**SLOT_BITS is representable.
    localparam logic [SLOT_BITS:0] SLOT_LIMIT  = (SLOT_BITS + 1)'(NUM_SLOTS);
    localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                          state_reg;
    state_t                          state_next;

    logic [7:0]                      cnt_reg;
    logic [NUM_SLOTS-1:0]            dev_sel_reg;
    logic                            write_reg;
    logic [REG_BITS-1:0]             reg_addr_reg;
    logic [DATA_W-1:0]               wdata_reg;
    logic                            rsp_valid_reg;
    logic                            rsp_error_reg;
    logic [DATA_W-1:0]               rsp_rdata_reg;

    logic [SLOT_BITS-1:0]            req_slot;
    logic                            req_reserved;
    logic [NUM_SLOTS-1:0]            sel_dec;
    logic [NUM_SLOTS-1:0][DATA_W-1:0] rdata_masked;
    logic [DATA_W-1:0]               rdata_sel;
    logic                            ack_hit;
    logic                            timeout_hit;

    // FSM action strobes
    logic                            load_req;
    logic                            to_access;
    logic                            rsp_ok;
    logic                            rsp_err;

    assign req_slot     = bus.req_addr[ADDR_W-1:REG_BITS];
    assign req_reserved = ({1'b0, req_slot} >= SLOT_LIMIT);

    // Only the latched slot's ack is seen because dev_sel_reg is one-hot.
    assign ack_hit      = |(bus.dev_ack & dev_sel_reg);
    assign timeout_hit  = (cnt_reg == TIMEOUT_CNT);

    // Per-slot select decode and read-data masking by the active select.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign sel_dec[gi]      = (req_slot == SLOT_BITS'(gi));
            assign rdata_masked[gi] = dev_sel_reg[gi] ? bus.dev_rdata[gi*DATA_W +: DATA_W]
                                                      : '0;
        end
    endgenerate

    // OR-combine the masked slices; at most one is non-zero.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rdata_sel = rdata_sel | rdata_masked[i];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and action strobes; an ack beats the timeout.
    always_comb begin
        state_next = state_reg;
        load_req   = 1'b0;
        to_access  = 1'b0;
        rsp_ok     = 1'b0;
        rsp_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    load_req = 1'b1;
                    if (req_reserved) begin
                        rsp_err    = 1'b1;
                        state_next = RESPOND;
                    end else begin
                        to_access  = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    rsp_ok     = 1'b1;
                    state_next = RESPOND;
                end else if (timeout_hit) begin
                    rsp_err    = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, wait counter, device select and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            dev_sel_reg   <= '0;
            write_reg     <= 1'b0;
            reg_addr_reg  <= '0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            if (load_req) begin
                write_reg    <= bus.req_write;
                reg_addr_reg <= bus.req_addr[REG_BITS-1:0];
                wdata_reg    <= bus.req_wdata;
                cnt_reg      <= '0;
            end else if (state_reg == ACCESS && !rsp_ok && !rsp_err) begin
                cnt_reg <= cnt_reg + 8'd1;
            end

            if (to_access) begin
                dev_sel_reg <= sel_dec;
            end else if (rsp_ok || rsp_err) begin
                dev_sel_reg <= '0;
            end

            // Response fields are live only for the single RESPOND cycle.
            rsp_valid_reg <= rsp_ok | rsp_err;
            rsp_error_reg <= rsp_err;
            rsp_rdata_reg <= (rsp_ok && !write_reg) ? rdata_sel : '0;
        end
    end

    assign bus.req_ready    = (state_reg == IDLE);
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_error    = rsp_error_reg;
    assign bus.rsp_rdata    = rsp_rdata_reg;
    assign bus.dev_sel      = dev_sel_reg;
    assign bus.dev_write    = write_reg;
    assign bus.dev_reg_addr = reg_addr_reg;
    assign bus.dev_wdata    = wdata_reg;

`ifdef IO_BUS_ROUTER_STATS_EN
    logic [SLOT_BITS-1:0] slot_reg;
    logic [7:0]           err_count_reg;
    logic [ADDR_W-1:0]    err_addr_reg;

    // Slot field kept only for error address reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (load_req) begin
            slot_reg <= req_slot;
        end
    end

    // Saturating error count and last error address, updated in RESPOND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= '0;
            err_addr_reg  <= '0;
        end else if (state_reg == RESPOND && rsp_error_reg) begin
            if (err_count_reg != 8'hFF) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
            err_addr_reg <= {slot_reg, reg_addr_reg};
        end
    end

    assign bus.err_count = err_count_reg;
    assign bus.err_addr  = err_addr_reg;
`endif

endmodule
